// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/ack and fetch-to-decode handshake bundle
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch FSM (IDLE/REQ/FLUSH) feeding a prefetch buffer; FETCH_STATS_EN adds flush_cnt
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]  flush_cnt
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

  state_t        state, state_n;
  logic          started;
  logic [31:0]   pc, pc_n;
  logic [31:0]   addr, addr_n;
  logic          req, req_n;
  logic [CW-1:0] count, count_n, fill;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   buf_pc  [FIFO_DEPTH];
  logic [31:0]   buf_ins [FIFO_DEPTH];
  logic          push, pop;

  // Redirect wins over everything: no push, no pop, buffer emptied.
  assign push    = (state == REQ) && bus.imem_ack && !bus.redirect;
  assign pop     = (count != '0) && bus.inst_ready && !bus.redirect;
  assign fill    = count + CW'(1) - CW'(pop);
  assign count_n = bus.redirect ? '0 : count + CW'(push) - CW'(pop);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = req;
    addr_n  = addr;
    case (state)
      IDLE: begin
        if (bus.redirect) begin
          pc_n = bus.redirect_pc;
        end else if (started && (count < DEPTH)) begin
          req_n   = 1'b1;
          addr_n  = pc;
          state_n = REQ;
        end
      end
      REQ: begin
        if (bus.redirect) begin
          pc_n = bus.redirect_pc;
          if (bus.imem_ack) begin
            req_n   = 1'b0;
            state_n = IDLE;
          end else begin
            state_n = FLUSH;
          end
        end else if (bus.imem_ack) begin
          pc_n = pc + 32'd1;
          if (fill < DEPTH) begin
            addr_n = pc + 32'd1;
          end else begin
            req_n   = 1'b0;
            state_n = IDLE;
          end
        end
      end
      FLUSH: begin
        if (bus.redirect) pc_n = bus.redirect_pc;
        if (bus.imem_ack) begin
          req_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // started delays the first request by one edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      started <= 1'b0;
      pc      <= RESET_PC;
      addr    <= RESET_PC;
      req     <= 1'b0;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state   <= state_n;
      started <= 1'b1;
      pc      <= pc_n;
      addr    <= addr_n;
      req     <= req_n;
      count   <= count_n;
      if (bus.redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]  <= pc;
      buf_ins[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = addr;
  assign bus.inst_valid = (count != '0);
  assign bus.inst       = (count != '0) ? buf_ins[rd_ptr] : '0;
  assign bus.inst_pc    = (count != '0) ? buf_pc[rd_ptr]  : '0;

`ifdef FETCH_STATS_EN
  logic        drop;
  logic [16:0] flush_sum;

  assign drop      = bus.imem_ack && ((state == FLUSH) || ((state == REQ) && bus.redirect));
  assign flush_sum = {1'b0, flush_cnt} + 17'(bus.redirect ? count : '0) + 17'(drop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flush_cnt <= '0;
    else      flush_cnt <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
  end
`endif
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the word-index PC loaded on reset.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the instruction buffer depth; legal values are powers of two from 2 to 16.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 imem_req  output  1  SHALL be asserted while an instruction-memory read request is pending.
REQ-006 imem_addr  output  32  SHALL carry the word-index address of the pending request.
REQ-007 imem_ack  input  1  SHALL be a one-cycle acknowledge; imem_rdata is valid in the same cycle.
REQ-008 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-009 inst_valid  output  1  SHALL indicate that inst and inst_pc hold a buffered instruction.
REQ-010 inst  output  32  SHALL be the instruction at the buffer head.
REQ-011 inst_pc  output  32  SHALL be the word-index PC of inst.
REQ-012 inst_ready  input  1  SHALL mean the downstream decode/control stage consumes the head this cycle.
REQ-013 redirect  input  1  SHALL be a one-cycle branch/jump redirect strobe.
REQ-014 redirect_pc  input  32  SHALL be the word-index redirect target, sampled when redirect=1.

Function
REQ-015 The PC SHALL be a word index; sequential next PC = pc+1, modulo 2^32 (32'hFFFF_FFFF wraps to 0).
REQ-016 The FSM SHALL have states IDLE, REQ and FLUSH.
REQ-017 In IDLE with no redirect and count<FIFO_DEPTH, the block SHALL register imem_req=1 and imem_addr=pc, then move to REQ.
REQ-018 In REQ, imem_req and imem_addr SHALL stay stable until imem_ack.
REQ-019 On imem_ack in REQ without redirect, the block SHALL push {pc, imem_rdata} and set pc=pc+1.
REQ-020 After that push, if the next count is below FIFO_DEPTH, the block SHALL keep imem_req=1 with imem_addr=pc+1 and stay in REQ; otherwise it SHALL drop imem_req and go to IDLE.
REQ-021 At most one request SHALL be outstanding, and the buffer SHALL never overflow.
REQ-022 A pop SHALL occur when inst_valid and inst_ready; a push and pop in the same cycle leave count unchanged.
REQ-023 inst_valid SHALL equal (count!=0), and inst/inst_pc SHALL come from the head entry registered, with no combinational path from imem_rdata.
REQ-024 Redirect SHALL take priority over all events: flush the buffer (count=0, inst_valid=0 next cycle), set pc=redirect_pc, and ignore any pop that cycle.
REQ-025 Redirect in REQ without imem_ack SHALL move the FSM to FLUSH, holding imem_req/imem_addr until ack, then discard the data, drop imem_req and go to IDLE.
REQ-026 Redirect coinciding with imem_ack SHALL discard the data, drop imem_req and go to IDLE.
REQ-027 Redirect in FLUSH SHALL update pc only and stay in FLUSH.
REQ-028 Redirect in IDLE SHALL update pc, and the next request SHALL use redirect_pc.
REQ-029 imem_ack outside REQ/FLUSH SHALL be ignored.
REQ-030 Best-case sustained throughput SHALL be one instruction per cycle, given a zero-wait memory and inst_ready=1.

Reset
REQ-031 rst=0 SHALL immediately force state=IDLE, pc=RESET_PC, count=0, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0 and inst_pc=0.
REQ-032 Reset asserted mid-request SHALL abandon the request, and any later ack SHALL be ignored.
REQ-033 The first request SHALL be issued on the second rising edge after rst deasserts.

Configuration
REQ-034 With macro FETCH_STATS_EN defined, the block SHALL add output flush_cnt [15:0]: reset 0, +1 per discarded instruction (flushed buffer entries plus any dropped ack data), saturating at 16'hFFFF.
REQ-035 With FETCH_STATS_EN undefined, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Reset release, memory acks 1 cycle after each req with rdata=addr+32'h100, inst_ready=1 -> inst_pc sequence 0,1,2,3, with inst=32'h100,32'h101,...
REQ-037 inst_ready=0 with an always-acking memory -> exactly 4 pushes, then imem_req=0 and inst_valid=1 with inst_pc=0 held; inst_ready=1 -> requests resume at addr 4.
REQ-038 redirect_pc=32'h40 while REQ is waiting on addr 2 -> ack for addr 2 discarded; next imem_addr=32'h40; first inst_pc after redirect is 32'h40.
REQ-039 redirect_pc=32'h80 coinciding with imem_ack and a pop -> buffer empty next cycle; next request addr 32'h80; with FETCH_STATS_EN, flush_cnt increments by the flushed count plus 1.
REQ-040 RESET_PC=32'hFFFF_FFFE -> fetches 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1.
REQ-041 rst pulsed low while imem_req=1 -> outputs at reset values in the same cycle; a late imem_ack produces no push.
